alu_cmd_driver: RTL and testbench
=================================

Name: alu_cmd_driver

Overview:
- Initiator-side companion to the team's registered 4-bit signed ALU (ops: ADD, SUB, NOT_A, REDUCTIONOR_B; 5-bit signed output C; one-cycle registered latency).
- Accepts tagged commands over a valid/ready channel and drives the ALU's opcode/A/B inputs.
- Captures the ALU's C at the correct cycle and returns it with its tag over a buffered valid/ready response channel.
- Also computes a golden result per command and flags any mismatch, so hardware self-test and UVM benches can use it as the ALU's active front end.

Parameters:
- RESP_DEPTH, 4, response FIFO depth; power of 2, ≥2.
- TAG_W, 4, width of the command/response tag.
- CNT_W, 16, width of the issue and error counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high. Shared with the ALU.
- cmd_valid  in  1  command present
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at posedge
- cmd_opcode  in  2  00 ADD, 01 SUB, 10 NOT_A, 11 REDUCTIONOR_B
- cmd_a  in  4  signed operand A
- cmd_b  in  4  signed operand B
- cmd_tag  in  TAG_W  opaque tag, returned with the result
- alu_opcode  out  2  to ALU opcode (registered)
- alu_a  out  4  to ALU A (registered)
- alu_b  out  4  to ALU B (registered)
- alu_c  in  5  from ALU C
- rsp_valid  out  1  response FIFO not empty
- rsp_ready  in  1  consumer pops when rsp_valid && rsp_ready at posedge
- rsp_c  out  5  captured ALU result (FIFO head)
- rsp_tag  out  TAG_W  tag of the head entry
- rsp_err  out  1  head entry's result mismatched the golden value
- err_sticky  out  1  set on any mismatch; cleared only by rst
- issue_count  out  CNT_W  commands accepted; wraps
- err_count  out  CNT_W  mismatches captured; saturates at all-ones

Behaviour:
- Reset values:
  - alu_opcode/alu_a/alu_b = 0.
  - FIFO empty: rsp_valid = 0; rsp_c, rsp_tag, rsp_err = 0.
  - Both in-flight stages invalid; err_sticky = 0; both counters = 0.
- Reset mid-operation discards all in-flight commands and FIFO contents; no response is produced for them.
- Issue (edge E0):
  - On accept, alu_opcode/a/b load the command fields.
  - Stage S1 loads {valid, tag, golden}.
  - alu_* hold their value when there is no accept.
- Pipeline timing:
  - Edge E1: the ALU registers C; S1 moves to S2.
  - Edge E2: alu_c is pushed into the FIFO with S2's tag, and rsp_err = (alu_c != golden).
  - Command-to-rsp_valid latency = 2 cycles from the accept edge into an empty FIFO.
  - Throughput is 1 command/cycle.
- Golden result (5-bit, computed on sign-extended operands):
  - ADD = sext(A) + sext(B).
  - SUB = sext(A) − sext(B).
  - NOT_A = ~sext(A), e.g. A = 4'b0101 -> 5'b11010.
  - REDUCTIONOR_B = {4'b0, |B}.
- Flow control (credit):
  - cmd_ready = (fifo_count + inflight_count) < RESP_DEPTH, where inflight_count = S1.valid + S2.valid.
  - This guarantees every capture finds space; the pipeline never stalls and alu_c is never dropped.
  - cmd_ready is combinational from registered state only (no path from cmd_valid or rsp_ready).
- FIFO:
  - A push and a pop in the same cycle are both performed and the count is unchanged.
  - A push and a pop on an empty FIFO cannot coincide, since the pop requires rsp_valid.
  - Read/write pointers wrap modulo RESP_DEPTH.
  - rsp_* is stable while rsp_valid && !rsp_ready.
- Counters:
  - issue_count increments on each accept and wraps.
  - err_count increments on each push with a mismatch and saturates.
  - err_sticky sets on the same event.
- Ordering: responses leave strictly in command order.

Test Plan:
- rst asserted mid-stream with 2 in flight -> all outputs at reset values immediately; after release, no stale response, issue_count = 0.
- Single ADD, A=7, B=1, tag=3, rsp_ready=1 -> rsp_valid high exactly 2 cycles after the accept; rsp_c = 5'b01000, rsp_tag = 3, rsp_err = 0.
- Back-to-back SUB (−8−7), NOT_A (A=5), REDUCTIONOR_B (B=0), then (B=4'b1000), tags 0..3:
  - rsp_c = 5'b10001, 5'b11010, 5'b00000, 5'b00001, in tag order.
  - issue_count = 4.
- rsp_ready=0 with continuous cmd_valid, RESP_DEPTH=4:
  - cmd_ready drops after exactly 4 accepts; FIFO holds 4 entries.
  - Raising rsp_ready drains them in order, and cmd_ready reasserts the cycle after the first pop.
- Force alu_c to 5'b11111 during an ADD 1+1:
  - rsp_err = 1, err_sticky = 1, err_count = 1.
  - A following correct op has rsp_err = 0 while err_sticky stays 1.
- Steady state with rsp_ready=1 and cmd_valid=1 for 20 cycles -> 20 accepts, 18 responses popped, push and pop coinciding each cycle with the FIFO count stable at 0–1.

Source files
------------

// File: rtl/alu_cmd_driver.sv
// Command front end for the registered 4-bit signed ALU: issues tagged ops, captures C two
// edges later, checks it against a golden result and returns it through a credit-managed FIFO.
module alu_cmd_driver #(
    parameter int RESP_DEPTH = 4,
    parameter int TAG_W      = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_opcode,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [1:0]       alu_opcode,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [4:0]       alu_c,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [4:0]       rsp_c,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] issue_count,
    output logic [CNT_W-1:0] err_count
);
    localparam int PW = $clog2(RESP_DEPTH);
    localparam int CW = PW + 2;
    localparam logic [CW-1:0] DEPTH_C = CW'(RESP_DEPTH);

    typedef struct packed {
        logic [4:0]       c;
        logic [TAG_W-1:0] tag;
        logic             err;
    } rsp_t;

    logic                  accept, push, pop, push_err;
    logic [4:0]            gold;
    logic [2:1]            vld_pipe;
    logic [2:1][TAG_W-1:0] tag_pipe;
    logic [2:1][4:0]       gold_pipe;
    logic [CW-1:0]         fifo_cnt, inflight;
    logic [PW-1:0]         rd_ptr, wr_ptr;
    rsp_t                  mem [RESP_DEPTH];
    rsp_t                  head;

    always_comb begin
        gold = '0;
        unique case (cmd_opcode)
            2'b00: gold = {cmd_a[3], cmd_a} + {cmd_b[3], cmd_b};
            2'b01: gold = {cmd_a[3], cmd_a} - {cmd_b[3], cmd_b};
            2'b10: gold = ~{cmd_a[3], cmd_a};
            2'b11: gold = {4'b0, |cmd_b};
        endcase
    end

    // Credit check counts in-flight ops so every capture is guaranteed a FIFO slot.
    assign inflight  = CW'(vld_pipe[1]) + CW'(vld_pipe[2]);
    assign cmd_ready = (fifo_cnt + inflight) < DEPTH_C;
    assign accept    = cmd_valid && cmd_ready;
    assign push      = vld_pipe[2];
    assign pop       = rsp_valid && rsp_ready;
    assign push_err  = push && (alu_c != gold_pipe[2]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_opcode <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            vld_pipe   <= '0;
            tag_pipe   <= '0;
            gold_pipe  <= '0;
        end else begin
            if (accept) begin
                alu_opcode <= cmd_opcode;
                alu_a      <= cmd_a;
                alu_b      <= cmd_b;
            end
            vld_pipe  <= {vld_pipe[1], accept};
            tag_pipe  <= {tag_pipe[1], cmd_tag};
            gold_pipe <= {gold_pipe[1], gold};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_cnt <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{c: alu_c, tag: tag_pipe[2], err: push_err};
    end

    // Empty FIFO presents zeros so stale or uninitialised storage never leaks out.
    assign rsp_valid = (fifo_cnt != '0);
    assign head      = rsp_valid ? mem[rd_ptr] : '0;
    assign rsp_c     = head.c;
    assign rsp_tag   = head.tag;
    assign rsp_err   = head.err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue_count <= '0;
            err_count   <= '0;
            err_sticky  <= 1'b0;
        end else begin
            if (accept) issue_count <= issue_count + CNT_W'(1);
            if (push_err) begin
                err_sticky <= 1'b1;
                if (err_count != '1) err_count <= err_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver: behavioural ALU stand-in plus an outstanding-command
// queue model that predicts readiness, response visibility, data order and counters.
module tb_alu_cmd_driver;
    localparam int DEPTH = 4;
    localparam int TW    = 4;
    localparam int CNW   = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic           cmd_valid, cmd_ready;
    logic [1:0]     cmd_opcode;
    logic [3:0]     cmd_a, cmd_b;
    logic [TW-1:0]  cmd_tag;
    logic [1:0]     alu_opcode;
    logic [3:0]     alu_a, alu_b;
    logic [4:0]     alu_c;
    logic           rsp_valid, rsp_ready;
    logic [4:0]     rsp_c;
    logic [TW-1:0]  rsp_tag;
    logic           rsp_err, err_sticky;
    logic [CNW-1:0] issue_count, err_count;
    logic           corrupt_en;

    always #5 clk = ~clk;

    alu_cmd_driver #(.RESP_DEPTH(DEPTH), .TAG_W(TW), .CNT_W(CNW)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c), .rsp_tag(rsp_tag),
        .rsp_err(rsp_err), .err_sticky(err_sticky), .issue_count(issue_count),
        .err_count(err_count)
    );

    // Registered ALU stand-in; corrupt_en breaks ADD 1+1 to exercise the mismatch path.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) alu_c <= '0;
        else if (corrupt_en && alu_opcode == 2'b00 && alu_a == 4'd1 && alu_b == 4'd1)
            alu_c <= 5'h1f;
        else case (alu_opcode)
            2'b00: alu_c <= {alu_a[3], alu_a} + {alu_b[3], alu_b};
            2'b01: alu_c <= {alu_a[3], alu_a} - {alu_b[3], alu_b};
            2'b10: alu_c <= ~{alu_a[3], alu_a};
            default: alu_c <= {4'b0, |alu_b};
        endcase
    end

    typedef struct {
        logic [TW-1:0] tag;
        logic [4:0]    c;
        logic          err;
        int            vis;
    } ent_t;

    ent_t       q[$];
    logic [4:0] got_c[$];
    logic [TW-1:0] got_tag[$];
    int n_cmp = 0, n_fail = 0;
    int cyc = 0, issue_m = 0, errc_m = 0, n_acc = 0, n_pop = 0;
    logic sticky_m = 1'b0;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Result in plain integer arithmetic on the signed operand values, kept to 5 bits.
    function automatic logic [4:0] ref_c(input logic [1:0] op, input logic [3:0] a,
                                         input logic [3:0] b);
        int sa, sb, r;
        sa = int'($signed(a));
        sb = int'($signed(b));
        case (op)
            2'd0: r = sa + sb;
            2'd1: r = sa - sb;
            2'd2: r = -sa - 1;
            default: r = (b != 4'd0) ? 1 : 0;
        endcase
        return r[4:0];
    endfunction

    task automatic drive(input logic v, input logic [1:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic [TW-1:0] t);
        cmd_valid = v; cmd_opcode = op; cmd_a = a; cmd_b = b; cmd_tag = t;
    endtask

    task automatic tick();
        logic exp_ready, exp_valid, acc, pp;
        logic [4:0] g, o;
        ent_t e;
        @(negedge clk);
        exp_ready = (q.size() < DEPTH);
        exp_valid = (q.size() > 0) && (q[0].vis <= cyc);
        chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("rsp_c", 32'(rsp_c), 32'(q[0].c));
            chk("rsp_tag", 32'(rsp_tag), 32'(q[0].tag));
            chk("rsp_err", 32'(rsp_err), 32'(q[0].err));
        end
        chk("issue_count", 32'(issue_count), 32'(issue_m % (1 << CNW)));
        chk("err_count", 32'(err_count), 32'(errc_m));
        chk("err_sticky", 32'(err_sticky), 32'(sticky_m));
        if (cmd_valid && cmd_ready) n_acc++;
        acc = cmd_valid && exp_ready;
        pp  = exp_valid && rsp_ready;
        g = ref_c(cmd_opcode, cmd_a, cmd_b);
        o = (corrupt_en && cmd_opcode == 2'd0 && cmd_a == 4'd1 && cmd_b == 4'd1) ? 5'h1f : g;
        @(posedge clk);
        cyc++;
        if (pp) begin
            got_c.push_back(rsp_c);
            got_tag.push_back(rsp_tag);
            void'(q.pop_front());
            n_pop++;
        end
        if (acc) begin
            e.tag = cmd_tag; e.c = o; e.err = (o != g); e.vis = cyc + 2;
            q.push_back(e);
            issue_m++;
        end
        foreach (q[i]) if (q[i].vis == cyc && q[i].err) begin
            sticky_m = 1'b1;
            if (errc_m < (1 << CNW) - 1) errc_m++;
        end
        #1;
    endtask

    initial begin
        rst = 1'b1; corrupt_en = 1'b0; rsp_ready = 1'b0;
        drive(1'b0, 2'd0, 4'd0, 4'd0, '0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
        chk("rst_rsp", 32'({rsp_c, rsp_tag, rsp_err}), 32'd0);
        chk("rst_counts", 32'({issue_count, err_count, err_sticky}), 32'd0);
        rst = 1'b0;

        // Single ADD 7+1, tag 3
        rsp_ready = 1'b1; got_c.delete(); got_tag.delete();
        drive(1'b1, 2'd0, 4'd7, 4'd1, 4'd3); tick();
        drive(1'b0, 2'd0, 4'd0, 4'd0, 4'd0); repeat (4) tick();
        chk("add_rsp_c", 32'(got_c[0]), 32'(5'b01000));
        chk("add_rsp_tag", 32'(got_tag[0]), 32'd3);

        // Back-to-back SUB, NOT_A, REDUCTIONOR_B x2
        got_c.delete(); got_tag.delete();
        drive(1'b1, 2'd1, 4'b1000, 4'd7, 4'd0); tick();
        drive(1'b1, 2'd2, 4'd5, 4'd0, 4'd1); tick();
        drive(1'b1, 2'd3, 4'd0, 4'b0000, 4'd2); tick();
        drive(1'b1, 2'd3, 4'd0, 4'b1000, 4'd3); tick();
        drive(1'b0, 2'd0, 4'd0, 4'd0, 4'd0); repeat (4) tick();
        chk("b2b_n", 32'(got_c.size()), 32'd4);
        chk("b2b_c0", 32'(got_c[0]), 32'(5'b10001));
        chk("b2b_c1", 32'(got_c[1]), 32'(5'b11010));
        chk("b2b_c2", 32'(got_c[2]), 32'(5'b00000));
        chk("b2b_c3", 32'(got_c[3]), 32'(5'b00001));
        chk("b2b_tags", 32'({got_tag[0], got_tag[1], got_tag[2], got_tag[3]}), 32'h0123);
        chk("b2b_issue", 32'(issue_count), 32'd5);

        // Backpressure: only RESP_DEPTH commands may be outstanding
        rsp_ready = 1'b0; n_acc = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 2'(i), 4'(i), 4'(i + 3), 4'(i + 8)); tick();
        end
        chk("bp_accepts", 32'(n_acc), 32'(DEPTH));
        drive(1'b0, 2'd0, 4'd0, 4'd0, 4'd0);
        rsp_ready = 1'b1; repeat (6) tick();

        // Corrupted ADD 1+1 followed by a correct SUB
        corrupt_en = 1'b1;
        drive(1'b1, 2'd0, 4'd1, 4'd1, 4'd5); tick();
        drive(1'b1, 2'd1, 4'd2, 4'd1, 4'd6); tick();
        drive(1'b0, 2'd0, 4'd0, 4'd0, 4'd0); repeat (4) tick();
        corrupt_en = 1'b0;
        chk("corrupt_sticky", 32'(err_sticky), 32'd1);
        chk("corrupt_count", 32'(err_count), 32'd1);

        // Steady state: 20 cycles of continuous commands and consumption
        n_acc = 0; n_pop = 0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 2'($urandom), 4'($urandom), 4'($urandom), 4'(i)); tick();
        end
        drive(1'b0, 2'd0, 4'd0, 4'd0, 4'd0); tick();
        chk("steady_accepts", 32'(n_acc), 32'd20);
        chk("steady_pops", 32'(n_pop), 32'd18);
        repeat (3) tick();

        // Random traffic with random backpressure
        corrupt_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 9) < 7), 2'($urandom), 4'($urandom_range(0, 3)),
                  4'($urandom_range(0, 3)), 4'($urandom));
            rsp_ready = ($urandom_range(0, 9) < 6);
            tick();
        end
        drive(1'b0, 2'd0, 4'd0, 4'd0, 4'd0); rsp_ready = 1'b1;
        repeat (8) tick();
        corrupt_en = 1'b0;

        // Reset with two commands in flight
        drive(1'b1, 2'd0, 4'd2, 4'd3, 4'd1); tick();
        drive(1'b1, 2'd1, 4'd4, 4'd1, 4'd2); tick();
        drive(1'b0, 2'd0, 4'd0, 4'd0, 4'd0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("midrst_alu", 32'({alu_opcode, alu_a, alu_b}), 32'd0);
        chk("midrst_counts", 32'({issue_count, err_count, err_sticky}), 32'd0);
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        q.delete(); issue_m = 0; errc_m = 0; sticky_m = 1'b0;
        @(posedge clk); cyc++;
        #1 rst = 1'b0;
        n_pop = 0;
        repeat (5) tick();
        chk("midrst_no_stale", 32'(n_pop), 32'd0);
        chk("midrst_issue", 32'(issue_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
